// File: rtl/dct2d_engine_if.sv
// Block-level handshake bundle for the 8x8 DCT/IDCT engine.
interface dct2d_engine_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_mode;
  logic [64*IN_W-1:0]    in_block;
  logic                  out_valid;
  logic                  out_ready;
  logic [64*OUT_W-1:0]   out_block;
  logic                  busy;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_mode, in_block, out_ready,
    input  in_ready, out_valid, out_block, busy
  );

  // Engine side.
  modport slave (
    input  in_valid, in_mode, in_block, out_ready,
    output in_ready, out_valid, out_block, busy
  );
endinterface

// File: rtl/dct2d_engine.sv
// 8x8 separable DCT/IDCT engine: one MAC per cycle, two 512-cycle passes,
// fixed-point with round-half-up and saturation between passes.
module dct2d_engine #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 11,
  parameter int unsigned MID_W     = 14,
  parameter int unsigned COEF_FRAC = 12,
  parameter int unsigned COEF_W    = 14
) (
  input  logic          clk,
  input  logic          rst,
  dct2d_engine_if.slave bus
);
  localparam int unsigned A_W   = (IN_W > MID_W) ? IN_W : MID_W;
  localparam int unsigned P_W   = A_W + COEF_W;
  localparam int unsigned ACC_W = A_W + COEF_W + 3;

  // Q15 magnitude of 0.5*cos(k*pi/16); k=4 doubles as the DC row value.
  function automatic int q15_mag(input int k);
    case (k)
      0:       return 16384;
      1:       return 16069;
      2:       return 15137;
      3:       return 13623;
      4:       return 11585;
      5:       return 9102;
      6:       return 6270;
      7:       return 3196;
      default: return 0;
    endcase
  endfunction

  // Builds C[u][x] rescaled from Q15 to COEF_FRAC fractional bits.
  function automatic logic [64*COEF_W-1:0] build_rom();
    logic [64*COEF_W-1:0] rom;
    int m, q, sh, v;
    rom = '0;
    sh  = 15 - int'(COEF_FRAC);
    for (int u = 0; u < 8; u++) begin
      for (int x = 0; x < 8; x++) begin
        if (u == 0) begin
          q = 11585;
        end else begin
          m = ((2 * x + 1) * u) % 32;
          if (m <= 8)       q = q15_mag(m);
          else if (m <= 16) q = -q15_mag(16 - m);
          else if (m <= 24) q = -q15_mag(m - 16);
          else              q = q15_mag(32 - m);
        end
        if (sh == 0) v = q;
        else         v = (q + (1 <<< (sh - 1))) >>> sh;
        rom[(u * 8 + x) * COEF_W +: COEF_W] = COEF_W'(v);
      end
    end
    return rom;
  endfunction

  localparam logic [64*COEF_W-1:0] COEF_ROM = build_rom();

  localparam logic signed [ACC_W-1:0] RND      = ACC_W'(64'sd1 <<< (COEF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MID_MAX  = ACC_W'((64'sd1 <<< (MID_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MID_MIN  = ACC_W'(-(64'sd1 <<< (MID_W - 1)));
  localparam logic signed [ACC_W-1:0] OUT_SMAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_SMIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));
  localparam logic signed [ACC_W-1:0] OUT_UMAX = ACC_W'((64'sd1 <<< OUT_W) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_OFS  = ACC_W'(64'sd1 <<< (OUT_W - 1));

  function automatic logic signed [COEF_W-1:0] coef(input logic [2:0] u, input logic [2:0] x);
    return $signed(COEF_ROM[{u, x} * COEF_W +: COEF_W]);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS1,
    S_PASS2,
    S_LOAD,
    S_OUT
  } state_t;

  state_t                    state;
  logic [8:0]                cnt;
  logic                      mode;
  logic signed [ACC_W-1:0]   acc;
  logic signed [IN_W-1:0]    x_mem [64];
  logic signed [MID_W-1:0]   t_mem [64];
  logic [OUT_W-1:0]          y_mem [64];
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic [64*OUT_W-1:0]       out_block_q;

  logic [2:0]                idx_i, idx_j, idx_k;
  logic signed [A_W-1:0]     op_a;
  logic signed [COEF_W-1:0]  op_c;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [ACC_W-1:0]   out_pre;
  logic signed [MID_W-1:0]   mid_res;
  logic [OUT_W-1:0]          out_res;

  // Loop order is i (outer), j, k (inner).
  assign idx_i = cnt[8:6];
  assign idx_j = cnt[5:3];
  assign idx_k = cnt[2:0];

  // Operand select: mode 0 uses C, mode 1 uses C transposed.
  always_comb begin
    op_a = '0;
    op_c = '0;
    if (state == S_PASS1) begin
      op_a = A_W'(x_mem[{idx_k, idx_j}]);
      op_c = mode ? coef(idx_k, idx_i) : coef(idx_i, idx_k);
    end else begin
      op_a = A_W'(t_mem[{idx_i, idx_k}]);
      op_c = mode ? coef(idx_k, idx_j) : coef(idx_j, idx_k);
    end
  end

  assign prod    = P_W'(op_a) * P_W'(op_c);
  assign acc_sum = acc + ACC_W'(prod);
  assign rnd     = (acc_sum + RND) >>> COEF_FRAC;

  // Saturate the rounded element for the intermediate and output matrices.
  always_comb begin
    mid_res = MID_W'(rnd);
    if (rnd > MID_MAX)      mid_res = MID_W'(MID_MAX);
    else if (rnd < MID_MIN) mid_res = MID_W'(MID_MIN);
    out_pre = rnd + OUT_OFS;
    out_res = OUT_W'(rnd);
    if (!mode) begin
      if (rnd > OUT_SMAX)      out_res = OUT_W'(OUT_SMAX);
      else if (rnd < OUT_SMIN) out_res = OUT_W'(OUT_SMIN);
    end else begin
      out_res = OUT_W'(out_pre);
      if (out_pre[ACC_W-1])        out_res = '0;
      else if (out_pre > OUT_UMAX) out_res = OUT_W'(OUT_UMAX);
    end
  end

  // Control FSM, MAC accumulator and matrix storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      mode        <= 1'b0;
      acc         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_block_q <= '0;
      for (int e = 0; e < 64; e++) begin
        x_mem[e] <= '0;
        t_mem[e] <= '0;
        y_mem[e] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Forward mode removes the pixel offset by flipping the MSB.
            for (int e = 0; e < 64; e++) begin
              if (bus.in_mode)
                x_mem[e] <= bus.in_block[e*IN_W +: IN_W];
              else
                x_mem[e] <= {~bus.in_block[e*IN_W + IN_W - 1], bus.in_block[e*IN_W +: IN_W - 1]};
            end
            mode       <= bus.in_mode;
            cnt        <= '0;
            acc        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= S_PASS1;
          end
        end
        S_PASS1: begin
          if (idx_k == 3'd7) begin
            t_mem[{idx_i, idx_j}] <= mid_res;
            acc <= '0;
          end else begin
            acc <= acc_sum;
          end
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511) state <= S_PASS2;
        end
        S_PASS2: begin
          if (idx_k == 3'd7) begin
            y_mem[{idx_i, idx_j}] <= out_res;
            acc <= '0;
          end else begin
            acc <= acc_sum;
          end
          cnt <= cnt + 9'd1;
          if (cnt == 9'd511) state <= S_LOAD;
        end
        S_LOAD: begin
          for (int e = 0; e < 64; e++) out_block_q[e*OUT_W +: OUT_W] <= y_mem[e];
          out_valid_q <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_block = out_block_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_dct2d_engine.sv
// Directed bench for dct2d_engine: forward (default widths) and inverse
// (IN_W=11, OUT_W=8) instances, backpressure, reset abort, back-to-back.
module tb_dct2d_engine;
  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  dct2d_engine_if #(.IN_W(8),  .OUT_W(11)) bus_a ();
  dct2d_engine_if #(.IN_W(11), .OUT_W(8))  bus_b ();

  dct2d_engine u_fwd (.clk(clk), .rst(rst), .bus(bus_a));
  dct2d_engine #(.IN_W(11), .OUT_W(8)) u_inv (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [703:0] obs, input logic [703:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [703:0] fill8(input int v);
    logic [703:0] r;
    r = '0;
    for (int e = 0; e < 64; e++) r[e*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [703:0] dc11(input int v);
    logic [703:0] r;
    r = '0;
    r[10:0] = 11'(v);
    return r;
  endfunction

  // Q15 basis from the cosine definition, rescaled to 12 fractional bits.
  function automatic int cq(input int u, input int x);
    real r;
    int  q;
    if (u == 0) begin
      q = 11585;
    end else begin
      r = 16384.0 * $cos(3.14159265358979 * real'((2 * x + 1) * u) / 16.0);
      q = int'(r);
    end
    return (q + 4) >>> 3;
  endfunction

  // Reference forward 2-D DCT for IN_W=8, MID_W=14, OUT_W=11.
  function automatic logic [703:0] golden_fwd(input logic [511:0] blk);
    longint x [8][8];
    longint t [8][8];
    longint acc, r;
    logic [703:0] res;
    res = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        x[i][j] = longint'(blk[(i*8+j)*8 +: 8]) - 128;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(cq(i, k)) * x[k][j];
        r = (acc + 2048) >>> 12;
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        t[i][j] = r;
      end
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 8; k++) acc += t[i][k] * longint'(cq(j, k));
        r = (acc + 2048) >>> 12;
        if (r > 1023) r = 1023;
        if (r < -1024) r = -1024;
        res[(i*8+j)*11 +: 11] = 11'(r);
      end
    return res;
  endfunction

  task automatic accept(input bit sel, input logic mode, input logic [703:0] blk,
                        input bit keep, output int t);
    int n;
    n = 0;
    @(negedge clk);
    if (sel) begin
      bus_b.in_mode = mode; bus_b.in_block = blk; bus_b.in_valid = 1'b1;
    end else begin
      bus_a.in_mode = mode; bus_a.in_block = blk[511:0]; bus_a.in_valid = 1'b1;
    end
    while (!(sel ? bus_b.in_ready : bus_a.in_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_ready", sel ? bus_b.in_ready : bus_a.in_ready, 1'b1);
    @(posedge clk);
    #1;
    t = cyc;
    if (!keep) begin
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input bit sel, output int t, output logic [703:0] blk);
    int n;
    n = 0;
    while (!(sel ? bus_b.out_valid : bus_a.out_valid) && n < 1100) begin
      @(negedge clk);
      n++;
    end
    chk1("out_valid_rise", sel ? bus_b.out_valid : bus_a.out_valid, 1'b1);
    t   = cyc;
    blk = sel ? {192'b0, bus_b.out_block} : bus_a.out_block;
  endtask

  task automatic run_blk(input string tag, input bit sel, input logic mode,
                         input logic [703:0] blk, input logic [703:0] exp);
    int ta, tb;
    logic [703:0] got;
    accept(sel, mode, blk, 1'b0, ta);
    wait_out(sel, tb, got);
    chk({tag, "_latency"}, tb - ta, 1025);
    chk_blk({tag, "_data"}, got, exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n;
    logic [703:0] got, held, blk1, blk2, grad, zero_blk;

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_mode = 1'b0; bus_a.in_block = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_mode = 1'b0; bus_b.in_block = '0; bus_b.out_ready = 1'b1;
    grad = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) grad[(r*8+c)*8 +: 8] = 8'(r * 32 + c * 4);
    blk1 = '0;
    blk2 = '0;
    for (int e = 0; e < 64; e++) begin
      blk1[e*8 +: 8] = 8'($urandom_range(0, 255));
      blk2[e*8 +: 8] = 8'($urandom_range(0, 255));
    end
    zero_blk = fill8(0);

    #12;
    chk1("rst_in_ready", bus_a.in_ready, 1'b1);
    chk1("rst_out_valid", bus_a.out_valid, 1'b0);
    chk1("rst_busy", bus_a.busy, 1'b0);
    chk_blk("rst_out_block", bus_a.out_block, '0);
    @(negedge clk);
    rst = 1'b0;

    // Forward, mid-grey block: all coefficients zero.
    accept(1'b0, 1'b0, fill8(128), 1'b0, t0);
    chk1("accept_in_ready_low", bus_a.in_ready, 1'b0);
    chk1("accept_busy_high", bus_a.busy, 1'b1);
    wait_out(1'b0, t1, got);
    chk("fwd128_latency", t1 - t0, 1025);
    chk_blk("fwd128_data", got, '0);
    @(posedge clk);
    #1;
    chk1("hs_out_valid_low", bus_a.out_valid, 1'b0);
    chk1("hs_in_ready_high", bus_a.in_ready, 1'b1);
    chk1("hs_busy_low", bus_a.busy, 1'b0);

    // Forward, extreme flat blocks.
    run_blk("fwd255", 1'b0, 1'b0, fill8(255), dc11(1015));
    run_blk("fwd0", 1'b0, 1'b0, fill8(0), dc11(-1024));

    // Inverse, DC-only blocks.
    run_blk("inv1015", 1'b1, 1'b1, dc11(1015), {192'b0, fill8(255)[511:0]});
    run_blk("inv1023", 1'b1, 1'b1, dc11(1023), {192'b0, fill8(255)[511:0]});
    run_blk("invm1024", 1'b1, 1'b1, dc11(-1024), '0);

    // Backpressure plus an in_valid pulse while busy.
    bus_a.out_ready = 1'b0;
    accept(1'b0, 1'b0, fill8(255), 1'b0, t0);
    repeat (3) @(negedge clk);
    bus_a.in_block = zero_blk[511:0];
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    chk1("pulse_in_ready", bus_a.in_ready, 1'b0);
    chk1("pulse_busy", bus_a.busy, 1'b1);
    bus_a.in_valid = 1'b0;
    wait_out(1'b0, t1, got);
    chk("bp_latency", t1 - t0, 1025);
    chk_blk("bp_data", got, dc11(1015));
    held = got;
    bus_a.in_mode  = 1'b0;
    bus_a.in_block = zero_blk[511:0];
    bus_a.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk1("bp_hold_valid", bus_a.out_valid, 1'b1);
      chk_blk("bp_hold_data", bus_a.out_block, held);
    end
    chk1("bp_hold_in_ready", bus_a.in_ready, 1'b0);
    bus_a.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk1("bp_hs_out_valid", bus_a.out_valid, 1'b0);
    chk1("bp_hs_in_ready", bus_a.in_ready, 1'b1);
    t2 = cyc;
    @(posedge clk);
    #1;
    chk1("bp_second_accept_busy", bus_a.busy, 1'b1);
    chk1("bp_second_accept_ready", bus_a.in_ready, 1'b0);
    t0 = cyc;
    bus_a.in_valid = 1'b0;
    wait_out(1'b0, t1, got);
    chk("bp_second_gap", t0 - t2, 1);
    chk("bp_second_latency", t1 - t0, 1025);
    chk_blk("bp_second_data", got, dc11(-1024));

    // Reset in the middle of PASS2 aborts the block.
    accept(1'b0, 1'b0, grad, 1'b0, t0);
    while (cyc < t0 + 700) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("midrst_in_ready", bus_a.in_ready, 1'b1);
    chk1("midrst_out_valid", bus_a.out_valid, 1'b0);
    chk1("midrst_busy", bus_a.busy, 1'b0);
    chk_blk("midrst_out_block", bus_a.out_block, '0);
    @(negedge clk);
    rst = 1'b0;
    run_blk("post_rst", 1'b0, 1'b0, grad, golden_fwd(grad[511:0]));

    // Back-to-back blocks with out_ready tied high.
    accept(1'b0, 1'b0, blk1, 1'b1, t0);
    bus_a.in_block = blk2[511:0];
    wait_out(1'b0, t1, got);
    chk("b2b_first_latency", t1 - t0, 1025);
    chk_blk("b2b_first_data", got, golden_fwd(blk1[511:0]));
    n = 0;
    while (!bus_a.in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    t2 = cyc;
    bus_a.in_valid = 1'b0;
    chk("b2b_period", t2 - t0, 1027);
    wait_out(1'b0, t1, got);
    chk("b2b_second_latency", t1 - t2, 1025);
    chk_blk("b2b_second_data", got, golden_fwd(blk2[511:0]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
